gshare_predictor: RTL and testbench

Parametrised global-history direction predictor for the pipelined core. It replaces the fixed 256x2-bit inline BHT and 8-bit history register. It adds selectable indexing modes, a speculative history with checkpoint repair on mispredict, a sequential table-initialisation sweep, and saturating statistics counters. Fetch queries it combinationally; EX resolves branches into it.

---
 rtl/gshare_predictor.sv | 153 +++++++++++++++
 tb/tb_gshare_predictor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// gshare_predictor: global-history branch direction predictor with a table of
// saturating counters, selectable index hashing, speculative history with
// checkpoint repair, a sequential init sweep and saturating statistics.
// Lookup is combinational (zero latency); resolve/repair take effect on the next edge.
// There is no backpressure. While the init sweep runs (ready=0), predict and
// resolve requests are ignored and pred_taken is held at 0.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   flush_tbl / ready           re-init request / table valid
//   pred_valid, pred_pc         fetch-side query
//   pred_taken, pred_idx,       predicted direction, index used,
//   pred_ghr                    and the history checkpoint before this branch
//   res_valid, res_idx, res_ghr EX-side resolve: index and checkpoint from prediction
//   res_taken, res_mispredict   actual outcome, mispredict flag
//   stat_branches,              saturating counts of resolved branches
//   stat_mispredicts            and of mispredicts
module gshare_predictor #(
  parameter int XLEN      = 32,
  parameter int IDX_BITS  = 8,
  parameter int GHR_BITS  = 8,
  parameter int CTR_BITS  = 2,
  parameter int CTR_INIT  = 1,
  parameter int HASH_MODE = 0,
  parameter int STAT_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_tbl,
  output logic                 ready,
  input  logic                 pred_valid,
  input  logic [XLEN-1:0]      pred_pc,
  output logic                 pred_taken,
  output logic [IDX_BITS-1:0]  pred_idx,
  output logic [GHR_BITS-1:0]  pred_ghr,
  input  logic                 res_valid,
  input  logic [IDX_BITS-1:0]  res_idx,
  input  logic [GHR_BITS-1:0]  res_ghr,
  input  logic                 res_taken,
  input  logic                 res_mispredict,
  output logic [STAT_BITS-1:0] stat_branches,
  output logic [STAT_BITS-1:0] stat_mispredicts
);

  localparam int ENTRIES = 1 << IDX_BITS;
  // History bits used by gselect: never more than half the index.
  localparam int H = (GHR_BITS < IDX_BITS / 2) ? GHR_BITS : IDX_BITS / 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX    = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT_V = CTR_BITS'(CTR_INIT);
  localparam logic [IDX_BITS-1:0] LAST_IDX   = '1;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e               state_q, state_d;
  logic [IDX_BITS-1:0]  init_ptr_q, init_ptr_d;
  logic [GHR_BITS-1:0]  ghr_q, ghr_d;
  logic [STAT_BITS-1:0] stat_br_q, stat_br_d;
  logic [STAT_BITS-1:0] stat_mp_q, stat_mp_d;
  logic [CTR_BITS-1:0]  tbl_q [ENTRIES];

  logic                 wr_en;
  logic [IDX_BITS-1:0]  wr_idx;
  logic [CTR_BITS-1:0]  wr_dat;
  logic [CTR_BITS-1:0]  res_ctr;
  logic [IDX_BITS-1:0]  pc_idx;
  logic [IDX_BITS-1:0]  idx;
  logic                 unused_sink;

  assign pc_idx = pred_pc[IDX_BITS+1:2];

  generate
    if (HASH_MODE == 1) begin : g_gselect
      assign idx = {ghr_q[H-1:0], pred_pc[IDX_BITS-H+1:2]};
    end else if (HASH_MODE == 2) begin : g_bimodal
      assign idx = pc_idx;
    end else begin : g_gshare
      assign idx = pc_idx ^ IDX_BITS'(ghr_q);
    end
  endgenerate

  // Bits of the query/checkpoint that no hashing mode consumes.
  assign unused_sink = ^{pred_pc, pc_idx, res_ghr};

  assign ready            = (state_q == S_RUN);
  assign pred_idx         = idx;
  assign pred_ghr         = ghr_q;
  assign pred_taken       = (state_q == S_RUN) & tbl_q[idx][CTR_BITS-1];
  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
  assign res_ctr          = tbl_q[res_idx];

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    ghr_d      = ghr_q;
    stat_br_d  = stat_br_q;
    stat_mp_d  = stat_mp_q;
    wr_en      = 1'b0;
    wr_idx     = res_idx;
    wr_dat     = res_ctr;
    unique case (state_q)
      S_INIT: begin
        // Sweep owns the single write port; resolves are ignored here.
        wr_en      = 1'b1;
        wr_idx     = init_ptr_q;
        wr_dat     = CTR_INIT_V;
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == LAST_IDX) state_d = S_RUN;
      end
      S_RUN: begin
        if (res_valid) begin
          wr_en = 1'b1;
          if (res_taken) wr_dat = (res_ctr == CTR_MAX) ? res_ctr : res_ctr + 1'b1;
          else           wr_dat = (res_ctr == '0)      ? res_ctr : res_ctr - 1'b1;
          if (stat_br_q != '1) stat_br_d = stat_br_q + 1'b1;
          if (res_mispredict && (stat_mp_q != '1)) stat_mp_d = stat_mp_q + 1'b1;
        end
        // Truncating the concatenation keeps the low GHR_BITS, i.e. a left
        // shift with the new outcome in bit 0 (also correct for GHR_BITS=1).
        // Repair wins: a same-cycle prediction is on the wrong path.
        if (res_valid && res_mispredict) ghr_d = GHR_BITS'({res_ghr, res_taken});
        else if (pred_valid)             ghr_d = GHR_BITS'({ghr_q, pred_taken});
        if (flush_tbl) begin
          state_d    = S_INIT;
          init_ptr_d = '0;
          ghr_d      = '0;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      init_ptr_q <= '0;
      ghr_q      <= '0;
      stat_br_q  <= '0;
      stat_mp_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      ghr_q      <= ghr_d;
      stat_br_q  <= stat_br_d;
      stat_mp_q  <= stat_mp_d;
    end
  end

  // Counter table: contents are undefined until the sweep finishes.
  always_ff @(posedge clk) begin
    if (wr_en) tbl_q[wr_idx] <= wr_dat;
  end

endmodule

// File: tb/tb_gshare_predictor.sv
module tb_gshare_predictor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        flush_tbl = 1'b0;
  logic        pred_valid = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        res_valid = 1'b0;
  logic [7:0]  res_idx = '0;
  logic [7:0]  res_ghr = '0;
  logic        res_taken = 1'b0;
  logic        res_mispredict = 1'b0;

  logic        ready, pred_taken;
  logic [7:0]  pred_idx, pred_ghr;
  logic [15:0] stat_branches, stat_mispredicts;

  logic        b_ready, b_pt_unused;
  logic [7:0]  b_pred_idx, b_ghr_unused;
  logic [3:0]  b_sb, b_sm;

  gshare_predictor dut (
    .clk(clk), .rst_n(rst_n), .flush_tbl(flush_tbl), .ready(ready),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_idx(pred_idx), .pred_ghr(pred_ghr),
    .res_valid(res_valid), .res_idx(res_idx), .res_ghr(res_ghr),
    .res_taken(res_taken), .res_mispredict(res_mispredict),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  gshare_predictor #(.HASH_MODE(2), .STAT_BITS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush_tbl(flush_tbl), .ready(b_ready),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(b_pt_unused),
    .pred_idx(b_pred_idx), .pred_ghr(b_ghr_unused),
    .res_valid(res_valid), .res_idx(res_idx), .res_ghr(res_ghr),
    .res_taken(res_taken), .res_mispredict(res_mispredict),
    .stat_branches(b_sb), .stat_mispredicts(b_sm)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: counters as plain integers 0..3, history as an int.
  int m_ctr [256];
  int m_ghr, m_ptr, m_sb, m_sm, m_sb4, m_sm4;
  bit m_init;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 1; m_ptr = 0; m_ghr = 0;
    m_sb = 0; m_sm = 0; m_sb4 = 0; m_sm4 = 0;
  endtask

  // One clock: check outputs against the model, advance the model, take the edge.
  task automatic cycle();
    int p, idx, pt, ng;
    #1;
    if (!rst_n) model_reset();
    p   = int'((pred_pc >> 2) & 32'hFF);
    idx = p ^ m_ghr;
    pt  = (m_init || m_ctr[idx] < 2) ? 0 : 1;
    chk("ready", ready, m_init ? 0 : 1);
    chk("pred_idx", pred_idx, idx);
    chk("pred_taken", pred_taken, pt);
    chk("pred_ghr", pred_ghr, m_ghr);
    chk("stat_branches", stat_branches, m_sb);
    chk("stat_mispredicts", stat_mispredicts, m_sm);
    chk("b_ready", b_ready, m_init ? 0 : 1);
    chk("b_pred_idx", b_pred_idx, p);
    chk("b_stat_branches", b_sb, m_sb4);
    chk("b_stat_mispredicts", b_sm, m_sm4);
    if (rst_n) begin
      if (m_init) begin
        m_ctr[m_ptr] = 1;
        m_ptr++;
        if (m_ptr == 256) m_init = 0;
      end else begin
        ng = m_ghr;
        if (res_valid) begin
          if (res_taken) m_ctr[res_idx] = (m_ctr[res_idx] == 3) ? 3 : m_ctr[res_idx] + 1;
          else           m_ctr[res_idx] = (m_ctr[res_idx] == 0) ? 0 : m_ctr[res_idx] - 1;
          if (m_sb < 65535) m_sb++;
          if (m_sb4 < 15) m_sb4++;
          if (res_mispredict) begin
            if (m_sm < 65535) m_sm++;
            if (m_sm4 < 15) m_sm4++;
          end
        end
        if (res_valid && res_mispredict) ng = ((int'(res_ghr) << 1) | int'(res_taken)) & 255;
        else if (pred_valid)             ng = ((m_ghr << 1) | pt) & 255;
        if (flush_tbl) begin
          m_init = 1; m_ptr = 0; m_ghr = 0;
        end else begin
          m_ghr = ng;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    flush_tbl = 0; pred_valid = 0; res_valid = 0; res_taken = 0; res_mispredict = 0;
  endtask

  task automatic resolve(input logic [7:0] idx, input logic [7:0] g, input logic t, input logic mp);
    res_valid = 1; res_idx = idx; res_ghr = g; res_taken = t; res_mispredict = mp;
    cycle();
    res_valid = 0; res_mispredict = 0;
  endtask

  task automatic randomize_inputs(input bit allow_flush);
    pred_valid     = $urandom_range(0, 1) == 1;
    pred_pc        = $urandom;
    res_valid      = $urandom_range(0, 1) == 1;
    res_idx        = 8'($urandom);
    res_ghr        = 8'($urandom);
    res_taken      = $urandom_range(0, 1) == 1;
    res_mispredict = $urandom_range(0, 3) == 0;
    flush_tbl      = allow_flush && ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    model_reset();
    // Reset, then sweep with pred_valid held high.
    #2 rst_n = 0;
    pred_valid = 1;
    cycle();
    cycle();
    rst_n = 1;
    for (int i = 0; i < 255; i++) begin
      pred_pc = $urandom;
      cycle();
    end
    chk("ready_at_255", ready, 0);
    cycle();
    chk("ready_at_256", ready, 1);
    chk("ghr_after_init", pred_ghr, 0);
    set_idle();

    // Counter saturation at index 0x10.
    pred_pc = 32'h40;
    #1;
    chk("idx_pc40", pred_idx, 8'h10);
    chk("taken_init", pred_taken, 0);
    resolve(8'h10, 8'h00, 1, 0);
    chk("taken_after_1T", pred_taken, 1);
    resolve(8'h10, 8'h00, 1, 0);
    resolve(8'h10, 8'h00, 1, 0);
    resolve(8'h10, 8'h00, 0, 0);
    chk("taken_sat_hi", pred_taken, 1);
    for (int i = 0; i < 3; i++) resolve(8'h10, 8'h00, 0, 0);
    resolve(8'h10, 8'h00, 1, 0);
    chk("taken_sat_lo", pred_taken, 0);

    // Speculative history and mispredict repair.
    resolve(8'h20, 8'h00, 1, 0);
    resolve(8'h21, 8'h00, 1, 0);
    pred_pc = 32'h80;
    pred_valid = 1;
    for (int i = 0; i < 3; i++) cycle();
    pred_valid = 0;
    chk("ghr_TTN", pred_ghr, 8'h06);
    pred_valid = 1;
    resolve(8'h23, 8'h01, 1, 1);
    pred_valid = 0;
    chk("ghr_repair", pred_ghr, 8'h03);
    chk("mispredicts_1", stat_mispredicts, 1);

    // gshare vs bimodal index for ghr=0xA5, pc=0x40.
    resolve(8'h00, 8'h52, 1, 1);
    pred_pc = 32'h40;
    #1;
    chk("ghr_A5", pred_ghr, 8'hA5);
    chk("gshare_idx", pred_idx, 8'hB5);
    chk("bimodal_idx", b_pred_idx, 8'h10);

    // Random traffic in RUN.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs(0);
      cycle();
    end
    set_idle();

    // Flush: sweep restores CTR_INIT everywhere, stats kept.
    flush_tbl = 1;
    cycle();
    flush_tbl = 0;
    chk("flush_ready", ready, 0);
    chk("flush_ghr", pred_ghr, 0);
    for (int i = 0; i < 256; i++) begin
      randomize_inputs(1);
      cycle();
    end
    set_idle();
    chk("flush_ready_back", ready, 1);
    for (int i = 0; i < 256; i++) begin
      pred_pc = i << 2;
      #1;
      chk("flush_ctr_init", pred_taken, 0);
      cycle();
    end

    // Reset pulse part-way through a sweep.
    flush_tbl = 1;
    cycle();
    flush_tbl = 0;
    for (int i = 0; i < 100; i++) cycle();
    rst_n = 0;
    cycle();
    rst_n = 1;
    chk("rst_stat_br", stat_branches, 0);
    chk("rst_stat_mp", stat_mispredicts, 0);
    for (int i = 0; i < 255; i++) cycle();
    chk("rst_ready_255", ready, 0);
    cycle();
    chk("rst_ready_256", ready, 1);

    // 20 resolves: 4-bit stats saturate at 15.
    for (int i = 0; i < 20; i++) resolve(8'($urandom), 8'h00, $urandom_range(0, 1) == 1, 0);
    chk("stat16_20", stat_branches, 20);
    chk("stat4_sat", b_sb, 15);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
